// File: rtl/overlay_fetch_if.sv
// Read port between the overlay prefetcher (master) and the SDRAM controller (slave).
//  ram_addr  : read byte address, valid while ram_rd=1
//  ram_rd    : single-cycle read request pulse
//  ram_ready : controller initialised; gates new requests only
//  ram_valid : single-cycle pulse, ram_data holds the response
//  ram_data  : {a[3:0],b[3:0],g[3:0],r[3:0]}
interface overlay_fetch_if #(
  parameter int unsigned ADDR_W = 25
);
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rd;
  logic              ram_ready;
  logic              ram_valid;
  logic [15:0]       ram_data;

  modport master (
    output ram_addr, ram_rd,
    input  ram_ready, ram_valid, ram_data
  );

  modport slave (
    input  ram_addr, ram_rd,
    output ram_ready, ram_valid, ram_data
  );
endinterface

// File: rtl/overlay_fetch.sv
// Overlay artwork prefetcher: fetches ARGB4444 words from SDRAM into a small FIFO
// ahead of the raster and hands one word to the colour mixer per active ce_pix.
//  clk_sys, reset_n : clock, async active-low reset
//  enable           : overlay in use; 0 flushes and outputs black
//  low_res          : 1 = stride 2*RES_BYTES, 0 = RES_BYTES
//  ce_pix, hblank, vblank : raster timing
//  ram              : SDRAM read port (master side)
//  pix_argb         : current overlay pixel (registered)
//  underflow        : sticky, active pixel requested while FIFO empty
module overlay_fetch #(
  parameter int unsigned ADDR_W    = 25,
  parameter int unsigned FIFO_LOG2 = 4,
  parameter int unsigned RES_BYTES = 2
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   low_res,
  input  logic                   ce_pix,
  input  logic                   hblank,
  input  logic                   vblank,
  overlay_fetch_if.master        ram,
  output logic [15:0]            pix_argb,
  output logic                   underflow
);

  localparam int unsigned DEPTH = 1 << FIFO_LOG2;
  localparam int unsigned CNT_W = FIFO_LOG2 + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t              state, state_next;
  logic                discard, discard_next;
  logic                rd_q, rd_next;
  logic [ADDR_W-1:0]   addr_q, addr_next;
  logic [ADDR_W-1:0]   fetch_addr, fetch_addr_next;
  logic                vblank_q;

  logic [15:0]          mem [DEPTH];
  logic [FIFO_LOG2-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;

  logic                 frame_start_c;
  logic                 flush_c;
  logic                 push_c;
  logic                 pop_c;
  logic                 empty_c;
  logic                 pop_ok_c;
  logic [ADDR_W-1:0]    stride_c;

  assign frame_start_c = vblank & ~vblank_q;
  assign flush_c       = frame_start_c | ~enable;
  assign pop_c         = ce_pix & ~hblank & ~vblank & enable;
  assign empty_c       = (count == '0);
  assign pop_ok_c      = pop_c & ~empty_c;
  assign stride_c      = low_res ? ADDR_W'(2 * RES_BYTES) : ADDR_W'(RES_BYTES);

  assign ram.ram_rd   = rd_q;
  assign ram.ram_addr = addr_q;

  // Fetch FSM state and registered request outputs
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      discard    <= 1'b0;
      rd_q       <= 1'b0;
      addr_q     <= '0;
      fetch_addr <= '0;
      vblank_q   <= 1'b0;
    end else begin
      state      <= state_next;
      discard    <= discard_next;
      rd_q       <= rd_next;
      addr_q     <= addr_next;
      fetch_addr <= fetch_addr_next;
      vblank_q   <= vblank;
    end
  end

  // Next-state: one read outstanding; a flush while a read is in flight drops its word
  always_comb begin
    state_next      = state;
    discard_next    = discard;
    rd_next         = 1'b0;
    addr_next       = addr_q;
    fetch_addr_next = fetch_addr;
    push_c          = 1'b0;
    case (state)
      IDLE: begin
        // count < DEPTH here also bounds count+outstanding, since nothing is in flight
        if (!flush_c && ram.ram_ready && (count < CNT_W'(DEPTH))) begin
          state_next      = REQ;
          rd_next         = 1'b1;
          addr_next       = fetch_addr;
          fetch_addr_next = fetch_addr + stride_c;
        end
      end
      REQ: begin
        state_next = WAIT;
        if (flush_c) discard_next = 1'b1;
      end
      WAIT: begin
        if (ram.ram_valid) begin
          state_next   = IDLE;
          push_c       = ~discard & ~flush_c;
          discard_next = 1'b0;
        end else if (flush_c) begin
          discard_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (flush_c) fetch_addr_next = '0;
  end

  // FIFO storage, no reset needed
  always_ff @(posedge clk_sys) begin
    if (push_c) mem[wr_ptr] <= ram.ram_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_c) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c)   wr_ptr <= wr_ptr + FIFO_LOG2'(1);
      if (pop_ok_c) rd_ptr <= rd_ptr + FIFO_LOG2'(1);
      count <= count + CNT_W'(push_c) - CNT_W'(pop_ok_c);
    end
  end

  // Pixel output and sticky underflow
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      pix_argb  <= '0;
      underflow <= 1'b0;
    end else begin
      if (!enable) begin
        pix_argb <= '0;
      end else if (pop_c) begin
        if (empty_c) begin
          pix_argb  <= '0;
          underflow <= 1'b1;
        end else begin
          pix_argb  <= mem[rd_ptr];
        end
      end
      // vblank is high at a frame start, so this never races a pop
      if (frame_start_c) underflow <= 1'b0;
    end
  end

endmodule
